uart_tx_fifo: RTL

//   Serial transmit end of the MMIO UART channel. Consumes the 1-cycle tx_en/tx_data

---
 rtl/uart_tx_fifo.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/uart_tx_fifo.sv
// UART transmitter with a write FIFO in front of the serializer.
// Accepts one byte per cycle and drains it as 8N1 frames, LSB first.
module uart_tx_fifo #(
    parameter int CLKS_PER_BIT = 868,
    parameter int FIFO_AW      = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               tx_en,
    input  logic [7:0]         tx_data,
    output logic               tx,
    output logic               busy,
    output logic               full,
    output logic               empty,
    output logic [FIFO_AW:0]   level,
    output logic               overflow
);

    localparam int DEPTH = 2 ** FIFO_AW;
    localparam int BW    = $clog2(CLKS_PER_BIT);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

    logic [7:0]         mem [DEPTH];
    logic [FIFO_AW-1:0] wr_q, rd_q;
    logic [FIFO_AW:0]   level_q, level_d;
    logic               full_q, empty_q, busy_q, ovf_q;
    state_e             state_q;
    logic [BW-1:0]      baud_q;
    logic [2:0]         bit_q;
    logic [7:0]         shift_q;
    logic               tx_q;
    logic               push, pop, baud_end, idle_d;

    always_comb begin
        push     = tx_en && !full_q;
        baud_end = (baud_q == BW'(CLKS_PER_BIT - 1));
        pop      = !empty_q &&
                   (state_q == IDLE || (state_q == STOP && baud_end));
        // FSM only lands in IDLE when it is idle or ends a stop bit without a pop
        idle_d   = !pop &&
                   (state_q == IDLE || (state_q == STOP && baud_end));
        level_d  = level_q;
        if (push && !pop) begin
            level_d = level_q + 1'b1;
        end else if (pop && !push) begin
            level_d = level_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_q] <= tx_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q    <= '0;
            rd_q    <= '0;
            level_q <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
            busy_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            if (push) wr_q <= wr_q + 1'b1;
            if (pop)  rd_q <= rd_q + 1'b1;
            level_q <= level_d;
            full_q  <= (level_d == (FIFO_AW + 1)'(DEPTH));
            empty_q <= (level_d == '0);
            busy_q  <= !idle_d || (level_d != '0);
            ovf_q   <= tx_en && full_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    tx_q <= 1'b1;
                    if (pop) begin
                        shift_q <= mem[rd_q];
                        baud_q  <= '0;
                        state_q <= START;
                        tx_q    <= 1'b0;
                    end
                end
                START: begin
                    if (baud_end) begin
                        baud_q  <= '0;
                        bit_q   <= '0;
                        state_q <= DATA;
                        tx_q    <= shift_q[0];
                    end else begin
                        baud_q <= baud_q + 1'b1;
                    end
                end
                DATA: begin
                    if (baud_end) begin
                        baud_q  <= '0;
                        shift_q <= shift_q >> 1;
                        if (bit_q == 3'd7) begin
                            state_q <= STOP;
                            tx_q    <= 1'b1;
                        end else begin
                            bit_q <= bit_q + 1'b1;
                            tx_q  <= shift_q[1];
                        end
                    end else begin
                        baud_q <= baud_q + 1'b1;
                    end
                end
                STOP: begin
                    if (baud_end) begin
                        baud_q <= '0;
                        if (pop) begin
                            shift_q <= mem[rd_q];
                            state_q <= START;
                            tx_q    <= 1'b0;
                        end else begin
                            state_q <= IDLE;
                            tx_q    <= 1'b1;
                        end
                    end else begin
                        baud_q <= baud_q + 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign tx       = tx_q;
    assign busy     = busy_q;
    assign full     = full_q;
    assign empty    = empty_q;
    assign level    = level_q;
    assign overflow = ovf_q;

endmodule
